ysyx_23060136_ifu_bht: RTL and testbench

YSYX_23060136_IFU_BHT -- requirements
Module: ysyx_23060136_IFU_BHT

---
 rtl/ysyx_23060136_ifu_bht.sv | 108 ++++++++++
 tb/tb_ysyx_23060136_ifu_bht.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_23060136_ifu_bht.sv
// Branch history table for the fetch stage.
//
// Direct-mapped table of 2^BHT_IDX_W entries. Each entry holds a valid bit, a
// tag, a taken target and a 2-bit saturating counter. The fetch PC is looked
// up combinationally. Resolved branches from EXU2 train the table on the
// following clock edge.
//
// Ports:
//   clk, rst          clock and asynchronous active-low reset
//   IFU_pc            fetch PC to predict
//   IFU_Btype         fetched instruction is a conditional branch
//   IFU_pre_take      predicted taken
//   IFU_pre_target    predicted target on a hit, zero otherwise
//   FORWARD_stallEX2  EXU2 stalled; training is held off
//   BHT_pc            PC of the resolved branch
//   BHT_pre_true      resolved branch, prediction was correct
//   BHT_pre_false     resolved branch, prediction was wrong
//   BHT_taken         actual outcome of the resolved branch
//   BHT_target        actual taken target
//   BHT_flush         invalidate all entries (fence.i)
module ysyx_23060136_ifu_bht #(
  parameter int BHT_IDX_W = 4,
  parameter int BITS_W    = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [BITS_W-1:0] IFU_pc,
  input  logic              IFU_Btype,
  output logic              IFU_pre_take,
  output logic [BITS_W-1:0] IFU_pre_target,
  input  logic              FORWARD_stallEX2,
  input  logic [BITS_W-1:0] BHT_pc,
  input  logic              BHT_pre_true,
  input  logic              BHT_pre_false,
  input  logic              BHT_taken,
  input  logic [BITS_W-1:0] BHT_target,
  input  logic              BHT_flush
);

  localparam int Entries = 1 << BHT_IDX_W;
  localparam int TAG_W   = BITS_W - BHT_IDX_W - 2;

  logic [Entries-1:0] valid_q;
  logic [TAG_W-1:0]   tag_q    [Entries];
  logic [BITS_W-1:0]  target_q [Entries];
  logic [1:0]         ctr_q    [Entries];

  // Lookup side
  logic [BHT_IDX_W-1:0] lk_idx;
  logic [TAG_W-1:0]     lk_tag;
  logic                 lk_hit;

  assign lk_idx = IFU_pc[BHT_IDX_W+1:2];
  assign lk_tag = IFU_pc[BITS_W-1:BHT_IDX_W+2];
  assign lk_hit = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);

  assign IFU_pre_take   = IFU_Btype && lk_hit && ctr_q[lk_idx][1];
  assign IFU_pre_target = lk_hit ? target_q[lk_idx] : '0;

  // Update side
  logic [BHT_IDX_W-1:0] up_idx;
  logic [TAG_W-1:0]     up_tag;
  logic                 up_hit;
  logic                 upd;

  assign up_idx = BHT_pc[BHT_IDX_W+1:2];
  assign up_tag = BHT_pc[BITS_W-1:BHT_IDX_W+2];
  assign up_hit = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
  // Both qualifiers high still yields a single write.
  assign upd    = (BHT_pre_true || BHT_pre_false) && !FORWARD_stallEX2;

  // Instruction-aligned PCs never use the two low bits.
  logic unused_pc_lsb;
  assign unused_pc_lsb = ^{IFU_pc[1:0], BHT_pc[1:0]};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < Entries; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= 2'b01;
      end
    end else if (BHT_flush) begin
      // Flush takes priority over any training in the same cycle.
      for (int i = 0; i < Entries; i++) begin
        valid_q[i] <= 1'b0;
        ctr_q[i]   <= 2'b01;
      end
    end else if (upd) begin
      if (up_hit) begin
        if (BHT_taken) begin
          if (ctr_q[up_idx] != 2'b11) ctr_q[up_idx] <= ctr_q[up_idx] + 2'd1;
          target_q[up_idx] <= BHT_target;
        end else begin
          if (ctr_q[up_idx] != 2'b00) ctr_q[up_idx] <= ctr_q[up_idx] - 2'd1;
        end
      end else if (BHT_taken) begin
        // Allocate weakly taken, evicting whatever occupied the slot.
        valid_q[up_idx]  <= 1'b1;
        tag_q[up_idx]    <= up_tag;
        target_q[up_idx] <= BHT_target;
        ctr_q[up_idx]    <= 2'b10;
      end
    end
  end

endmodule

// File: tb/tb_ysyx_23060136_ifu_bht.sv
module tb_ysyx_23060136_ifu_bht;

  logic        clk;
  logic        rst;
  logic [31:0] IFU_pc;
  logic        IFU_Btype;
  logic        IFU_pre_take;
  logic [31:0] IFU_pre_target;
  logic        FORWARD_stallEX2;
  logic [31:0] BHT_pc;
  logic        BHT_pre_true;
  logic        BHT_pre_false;
  logic        BHT_taken;
  logic [31:0] BHT_target;
  logic        BHT_flush;

  ysyx_23060136_ifu_bht #(
    .BHT_IDX_W(4),
    .BITS_W   (32)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .IFU_pc          (IFU_pc),
    .IFU_Btype       (IFU_Btype),
    .IFU_pre_take    (IFU_pre_take),
    .IFU_pre_target  (IFU_pre_target),
    .FORWARD_stallEX2(FORWARD_stallEX2),
    .BHT_pc          (BHT_pc),
    .BHT_pre_true    (BHT_pre_true),
    .BHT_pre_false   (BHT_pre_false),
    .BHT_taken       (BHT_taken),
    .BHT_target      (BHT_target),
    .BHT_flush       (BHT_flush)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: 16 slots addressed by word index mod 16, tag = pc / 64.
  bit          m_valid [16];
  int unsigned m_tag   [16];
  int unsigned m_tgt   [16];
  int          m_ctr   [16];

  function automatic int slot(input logic [31:0] pc);
    return int'((pc / 4) % 16);
  endfunction

  function automatic bit m_hit(input logic [31:0] pc);
    return m_valid[slot(pc)] && (m_tag[slot(pc)] == pc / 64);
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 16; i++) begin
      m_valid[i] = 1'b0;
      m_ctr[i]   = 1;
    end
  endtask

  task automatic m_train(input bit stall, input logic [31:0] bpc, input bit pt, input bit pf,
                         input bit tk, input logic [31:0] tgt, input bit fl);
    int s;
    s = slot(bpc);
    if (fl) begin
      m_reset();
    end else if ((pt || pf) && !stall) begin
      if (m_hit(bpc)) begin
        if (tk) begin
          m_ctr[s] = (m_ctr[s] + 1 > 3) ? 3 : m_ctr[s] + 1;
          m_tgt[s] = tgt;
        end else begin
          m_ctr[s] = (m_ctr[s] - 1 < 0) ? 0 : m_ctr[s] - 1;
        end
      end else if (tk) begin
        m_valid[s] = 1'b1;
        m_tag[s]   = bpc / 64;
        m_tgt[s]   = tgt;
        m_ctr[s]   = 2;
      end
    end
  endtask

  task automatic chk(input string name);
    bit          exp_take;
    logic [31:0] exp_tgt;
    exp_take = IFU_Btype && m_hit(IFU_pc) && (m_ctr[slot(IFU_pc)] >= 2);
    exp_tgt  = m_hit(IFU_pc) ? m_tgt[slot(IFU_pc)] : 32'h0;
    n_checks++;
    assert (IFU_pre_take === exp_take) else begin
      n_fail++;
      $error("FAIL %s take: got %0b expected %0b (pc %h)", name, IFU_pre_take, exp_take, IFU_pc);
    end
    n_checks++;
    assert (IFU_pre_target === exp_tgt) else begin
      n_fail++;
      $error("FAIL %s target: got %h expected %h (pc %h)", name, IFU_pre_target, exp_tgt, IFU_pc);
    end
  endtask

  // One clock cycle: drive, check the lookup before the edge, clock, train the model.
  task automatic cyc(input string name, input logic [31:0] pc, input bit bt, input bit stall,
                     input logic [31:0] bpc, input bit pt, input bit pf, input bit tk,
                     input logic [31:0] tgt, input bit fl);
    IFU_pc           = pc;
    IFU_Btype        = bt;
    FORWARD_stallEX2 = stall;
    BHT_pc           = bpc;
    BHT_pre_true     = pt;
    BHT_pre_false    = pf;
    BHT_taken        = tk;
    BHT_target       = tgt;
    BHT_flush        = fl;
    #2;
    chk(name);
    @(posedge clk);
    #1;
    m_train(stall, bpc, pt, pf, tk, tgt, fl);
  endtask

  task automatic look(input string name, input logic [31:0] pc, input bit bt);
    cyc(name, pc, bt, 1'b0, $urandom, 1'b0, 1'b0, $urandom_range(0, 1), $urandom, 1'b0);
  endtask

  localparam logic [31:0] PcA  = 32'h8000_0010;
  localparam logic [31:0] PcB  = 32'h8000_0050;
  localparam logic [31:0] PcC  = 32'h8000_0090;
  localparam logic [31:0] TgtA = 32'h8000_0100;

  initial begin
    rst = 1'b1;
    IFU_pc = PcA; IFU_Btype = 1'b1; FORWARD_stallEX2 = 1'b0; BHT_pc = '0;
    BHT_pre_true = 1'b0; BHT_pre_false = 1'b0; BHT_taken = 1'b0; BHT_target = '0;
    BHT_flush = 1'b0;
    m_reset();
    #3 rst = 1'b0;
    #1 chk("reset_async");
    @(posedge clk);
    #1 rst = 1'b1;

    look("after_reset", PcA, 1'b1);

    // Allocate; the same-cycle lookup still sees the empty slot.
    cyc("alloc_same_cycle", PcA, 1'b1, 1'b0, PcA, 1'b0, 1'b1, 1'b1, TgtA, 1'b0);
    look("alloc_visible", PcA, 1'b1);

    // Saturate up, then walk down to weakly not-taken.
    for (int i = 0; i < 3; i++)
      cyc("sat_up", PcA, 1'b1, 1'b0, PcA, 1'b1, 1'b0, 1'b1, TgtA, 1'b0);
    look("sat_top", PcA, 1'b1);
    for (int i = 0; i < 2; i++)
      cyc("walk_down", PcA, 1'b1, 1'b0, PcA, 1'b1, 1'b0, 1'b0, 32'hdead_beef, 1'b0);
    look("weak_not_taken", PcA, 1'b1);
    look("btype_low", PcA, 1'b0);

    // Alias at the same slot evicts the old tag.
    cyc("alias_alloc", PcA, 1'b1, 1'b0, PcB, 1'b0, 1'b1, 1'b1, 32'h8000_0200, 1'b0);
    look("alias_old_miss", PcA, 1'b1);
    look("alias_new_hit", PcB, 1'b1);

    // Stall blocks training entirely.
    cyc("stall_upd", PcC, 1'b1, 1'b1, PcC, 1'b1, 1'b1, 1'b1, 32'h8000_0300, 1'b0);
    look("stall_no_alloc", PcC, 1'b1);

    // Both qualifiers high is a single write.
    cyc("both_qual", PcB, 1'b1, 1'b0, PcB, 1'b1, 1'b1, 1'b1, 32'h8000_0400, 1'b0);
    look("both_qual_after", PcB, 1'b1);

    // Flush beats a simultaneous allocation.
    cyc("flush_upd", PcC, 1'b1, 1'b0, PcC, 1'b1, 1'b0, 1'b1, 32'h8000_0500, 1'b1);
    look("flush_c", PcC, 1'b1);
    look("flush_b", PcB, 1'b1);

    // Not-taken miss never allocates.
    cyc("nt_miss", PcA, 1'b1, 1'b0, PcA, 1'b0, 1'b1, 1'b0, 32'h8000_0600, 1'b0);
    look("nt_miss_after", PcA, 1'b1);

    // Randomized training over a small PC pool to provoke hits and aliasing.
    for (int i = 0; i < 400; i++) begin
      logic [31:0] lpc, upc;
      lpc = 32'h8000_0000 | ($urandom_range(0, 3) << 6) | ($urandom_range(0, 15) << 2);
      upc = 32'h8000_0000 | ($urandom_range(0, 3) << 6) | ($urandom_range(0, 15) << 2);
      if ($urandom_range(0, 1)) upc = lpc;
      cyc("random", lpc, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 4) == 0), upc,
          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) != 0),
          $urandom, 1'($urandom_range(0, 40) == 0));
    end

    // Reset asserted in the middle of an update cycle.
    cyc("pre_mid_alloc", PcC, 1'b1, 1'b0, PcC, 1'b1, 1'b0, 1'b1, 32'h8000_0700, 1'b0);
    IFU_pc = PcC; IFU_Btype = 1'b1; BHT_pc = PcB; BHT_pre_true = 1'b1; BHT_taken = 1'b1;
    BHT_target = 32'h8000_0800; BHT_flush = 1'b0; FORWARD_stallEX2 = 1'b0;
    #2 rst = 1'b0;
    m_reset();
    #1 chk("mid_reset_c");
    @(posedge clk);
    #1 rst = 1'b1;
    look("post_reset_b", PcB, 1'b1);
    look("post_reset_c", PcC, 1'b1);

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule
